// File: rtl/pix_mem_write_ctrl.sv
// Ping-pong frame writer: packs two ADC channels into 32-bit words, writes them
// into the bank owned by the capture side and hands completed banks to the reader.
module pix_mem_write_ctrl #(
  parameter int ADC_W       = 14,
  parameter int ADDR_W      = 11,
  parameter int FRAME_WORDS = 768
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FRAME_START,
  input  logic              PIX_VALID,
  input  logic [ADC_W-1:0]  CAN_IN1,
  input  logic [ADC_W-1:0]  CAN_IN2,
  input  logic              TYPE_BAL,
  input  logic              READ_DONE,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DATA,
  output logic              FRAME_DONE,
  output logic              RD_BANK,
  output logic [1:0]        BANK_FULL,
  output logic              BUSY,
  output logic              OVERRUN,
  output logic              SYNC_ERR
);

  typedef enum logic [0:0] {IDLE = 1'b0, CAPTURE = 1'b1} state_t;

  localparam logic [ADDR_W-2:0] LAST_IDX = (ADDR_W-1)'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-2:0] CNT_ONE  = (ADDR_W-1)'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-2:0]   count_q, count_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic [1:0]          bank_set_s, bank_clr_s;
  logic                type_bal_q, type_bal_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                sync_err_q, sync_err_d;

  // Capture sequencing, word packing and bank hand-off between writer and reader.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    type_bal_d   = type_bal_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    sync_err_d   = 1'b0;
    bank_set_s   = 2'b00;
    bank_clr_s   = 2'b00;

    case (state_q)
      IDLE: begin
        if (FRAME_START) begin
          if (bank_full_q[wr_bank_q]) begin
            overrun_d = 1'b1;
          end else begin
            state_d    = CAPTURE;
            count_d    = '0;
            type_bal_d = TYPE_BAL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        // A new frame start restarts the same bank; the sample of that cycle is dropped.
        if (FRAME_START) begin
          sync_err_d = 1'b1;
          count_d    = '0;
          type_bal_d = TYPE_BAL;
        end else if (PIX_VALID) begin
          mem_we_d                = 1'b1;
          mem_addr_d              = {wr_bank_q, count_q};
          mem_data_d              = 32'h0000_0000;
          mem_data_d[ADC_W-1:0]   = CAN_IN1;
          mem_data_d[16 +: ADC_W] = type_bal_q ? CAN_IN2 : {ADC_W{1'b0}};
          if (count_q == LAST_IDX) begin
            bank_set_s[wr_bank_q] = 1'b1;
            frame_done_d          = 1'b1;
            wr_bank_d             = ~wr_bank_q;
            count_d               = '0;
            state_d               = IDLE;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (READ_DONE && bank_full_q[rd_bank_q]) begin
      bank_clr_s[rd_bank_q] = 1'b1;
      rd_bank_d             = ~rd_bank_q;
    end else begin
      rd_bank_d = rd_bank_q;
    end

    bank_full_d = (bank_full_q & ~bank_clr_s) | bank_set_s;
    busy_d      = (state_d == CAPTURE);
  end

  // State and registered outputs; reset discards any partial frame and empties both banks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      count_q      <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      type_bal_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= 32'h0000_0000;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      type_bal_q   <= type_bal_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign MEM_WE     = mem_we_q;
  assign MEM_ADDR   = mem_addr_q;
  assign MEM_DATA   = mem_data_q;
  assign FRAME_DONE = frame_done_q;
  assign RD_BANK    = rd_bank_q;
  assign BANK_FULL  = bank_full_q;
  assign BUSY       = busy_q;
  assign OVERRUN    = overrun_q;
  assign SYNC_ERR   = sync_err_q;

endmodule

// File: tb/tb_pix_mem_write_ctrl.sv
// Scoreboard bench for pix_mem_write_ctrl with a 4-word frame; every RAM write
// is popped against the expected {addr, data, frame_done} pushed at stimulus time.
module tb_pix_mem_write_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FRAME_START = 1'b0;
  logic        PIX_VALID = 1'b0;
  logic [13:0] CAN_IN1 = 14'h0;
  logic [13:0] CAN_IN2 = 14'h0;
  logic        TYPE_BAL = 1'b0;
  logic        READ_DONE = 1'b0;
  logic        MEM_WE;
  logic [10:0] MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic        FRAME_DONE;
  logic        RD_BANK;
  logic [1:0]  BANK_FULL;
  logic        BUSY;
  logic        OVERRUN;
  logic        SYNC_ERR;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [10:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;
  wr_t exp_q[$];
  wr_t exp_e;

  pix_mem_write_ctrl #(.ADC_W(14), .ADDR_W(11), .FRAME_WORDS(4)) dut (
    .CLK(CLK), .RST(RST), .FRAME_START(FRAME_START), .PIX_VALID(PIX_VALID),
    .CAN_IN1(CAN_IN1), .CAN_IN2(CAN_IN2), .TYPE_BAL(TYPE_BAL), .READ_DONE(READ_DONE),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .FRAME_DONE(FRAME_DONE),
    .RD_BANK(RD_BANK), .BANK_FULL(BANK_FULL), .BUSY(BUSY), .OVERRUN(OVERRUN),
    .SYNC_ERR(SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  // Every write seen on the RAM port must match the oldest expected entry.
  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: got addr=%h data=%h done=%b, required no write",
                 MEM_ADDR, MEM_DATA, FRAME_DONE);
      end else begin
        exp_e = exp_q.pop_front();
        if ({MEM_ADDR, MEM_DATA, FRAME_DONE} !== {exp_e.addr, exp_e.data, exp_e.last}) begin
          tests_failed++;
          $display("FAIL write: got addr=%h data=%h done=%b, required addr=%h data=%h done=%b",
                   MEM_ADDR, MEM_DATA, FRAME_DONE, exp_e.addr, exp_e.data, exp_e.last);
        end
      end
    end else if (FRAME_DONE === 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL frame_done_without_write: got FRAME_DONE=1, required 0");
    end
  end

  function automatic logic [31:0] pack(input logic [13:0] c1, input logic [13:0] c2,
                                       input logic bal);
    return {2'b00, (bal ? c2 : 14'h0000), 2'b00, c1};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic word(input logic bank, input int idx, input logic [13:0] c1,
                      input logic [13:0] c2, input logic bal);
    wr_t e;
    e.addr = {bank, 10'(idx)};
    e.data = pack(c1, c2, bal);
    e.last = (idx == 3);
    exp_q.push_back(e);
    PIX_VALID = 1'b1;
    CAN_IN1   = c1;
    CAN_IN2   = c2;
    tick();
    PIX_VALID = 1'b0;
  endtask

  task automatic start_frame(input logic bal);
    FRAME_START = 1'b1;
    TYPE_BAL    = bal;
    tick();
    FRAME_START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({MEM_WE, MEM_ADDR, MEM_DATA, FRAME_DONE, RD_BANK, BANK_FULL, BUSY, OVERRUN, SYNC_ERR} !== 50'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h done=%b rd=%b full=%b busy=%b ovr=%b sync=%b, required all 0",
               MEM_WE, MEM_ADDR, MEM_DATA, FRAME_DONE, RD_BANK, BANK_FULL, BUSY, OVERRUN, SYNC_ERR);
    end
    RST = 1'b0;
    PIX_VALID = 1'b1;
    tick();
    PIX_VALID = 1'b0;
  endtask

  task automatic test_basic_frame();
    start_frame(1'b1);
    tests_run++;
    if (BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_busy: got %b, required 1", BUSY);
    end
    for (int i = 0; i < 4; i++) word(1'b0, i, 14'h3FFF, 14'h0001, 1'b1);
    tests_run++;
    if ({BANK_FULL, RD_BANK, BUSY} !== {2'b01, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_done_state: got full=%b rd=%b busy=%b, required full=01 rd=0 busy=0",
               BANK_FULL, RD_BANK, BUSY);
    end
    tick();
  endtask

  task automatic test_type_bal_latch();
    start_frame(1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) TYPE_BAL = 1'b1;
      word(1'b1, i, 14'(14'h1230 + i), 14'h2AAA, 1'b0);
    end
    tests_run++;
    if (BANK_FULL !== 2'b11) begin
      tests_failed++;
      $display("FAIL typebal_full: got %b, required 11", BANK_FULL);
    end
    tick();
  endtask

  task automatic test_overrun();
    FRAME_START = 1'b1;
    PIX_VALID   = 1'b1;
    tick();
    FRAME_START = 1'b0;
    tests_run++;
    if ({OVERRUN, BUSY} !== 2'b10) begin
      tests_failed++;
      $display("FAIL overrun_pulse: got ovr=%b busy=%b, required ovr=1 busy=0", OVERRUN, BUSY);
    end
    tick();
    PIX_VALID = 1'b0;
    tests_run++;
    if ({OVERRUN, BANK_FULL} !== 3'b011) begin
      tests_failed++;
      $display("FAIL overrun_after: got ovr=%b full=%b, required ovr=0 full=11", OVERRUN, BANK_FULL);
    end
    READ_DONE = 1'b1;
    tick();
    READ_DONE = 1'b0;
    tests_run++;
    if ({BANK_FULL, RD_BANK} !== 3'b101) begin
      tests_failed++;
      $display("FAIL overrun_read_done: got full=%b rd=%b, required full=10 rd=1", BANK_FULL, RD_BANK);
    end
  endtask

  task automatic test_read_and_done_same_cycle();
    start_frame(1'b1);
    for (int i = 0; i < 3; i++) word(1'b0, i, 14'(14'h0111 * i), 14'(14'h3FFF - i), 1'b1);
    READ_DONE = 1'b1;
    word(1'b0, 3, 14'h0333, 14'h3FFC, 1'b1);
    READ_DONE = 1'b0;
    tests_run++;
    if ({BANK_FULL, RD_BANK} !== 3'b010) begin
      tests_failed++;
      $display("FAIL rd_and_done: got full=%b rd=%b, required full=01 rd=0", BANK_FULL, RD_BANK);
    end
    tick();
  endtask

  task automatic test_sync_err();
    FRAME_START = 1'b1;
    PIX_VALID   = 1'b1;
    TYPE_BAL    = 1'b1;
    tick();
    FRAME_START = 1'b0;
    PIX_VALID   = 1'b0;
    word(1'b1, 0, 14'h0AAA, 14'h1555, 1'b1);
    word(1'b1, 1, 14'h0BBB, 14'h1666, 1'b1);
    FRAME_START = 1'b1;
    PIX_VALID   = 1'b1;
    TYPE_BAL    = 1'b0;
    tick();
    FRAME_START = 1'b0;
    PIX_VALID   = 1'b0;
    tests_run++;
    if ({SYNC_ERR, BUSY} !== 2'b11) begin
      tests_failed++;
      $display("FAIL sync_pulse: got sync=%b busy=%b, required sync=1 busy=1", SYNC_ERR, BUSY);
    end
    TYPE_BAL = 1'b1;
    for (int i = 0; i < 4; i++) word(1'b1, i, 14'(14'h2000 + i), 14'h3333, 1'b0);
    tests_run++;
    if ({SYNC_ERR, BANK_FULL} !== 3'b011) begin
      tests_failed++;
      $display("FAIL sync_after: got sync=%b full=%b, required sync=0 full=11", SYNC_ERR, BANK_FULL);
    end
    for (int i = 0; i < 3; i++) begin
      READ_DONE = 1'b1;
      tick();
    end
    READ_DONE = 1'b0;
    tests_run++;
    if ({BANK_FULL, RD_BANK} !== 3'b000) begin
      tests_failed++;
      $display("FAIL drain_ignore_empty: got full=%b rd=%b, required full=00 rd=0", BANK_FULL, RD_BANK);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_frame(1'b1);
    word(1'b0, 0, 14'h0F0F, 14'h00F0, 1'b1);
    word(1'b0, 1, 14'h0E0E, 14'h00E0, 1'b1);
    RST       = 1'b1;
    PIX_VALID = 1'b1;
    tick();
    RST       = 1'b0;
    PIX_VALID = 1'b0;
    tests_run++;
    if ({MEM_WE, MEM_ADDR, MEM_DATA, FRAME_DONE, RD_BANK, BANK_FULL, BUSY, OVERRUN, SYNC_ERR} !== 50'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: got we=%b addr=%h data=%h full=%b busy=%b, required all 0",
               MEM_WE, MEM_ADDR, MEM_DATA, BANK_FULL, BUSY);
    end
    start_frame(1'b1);
    word(1'b0, 0, 14'h1111, 14'h2222, 1'b1);
    tick();
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_type_bal_latch();
    test_overrun();
    test_read_and_done_same_cycle();
    test_sync_err();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
